// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: shared types and constants for the dma_copy word-copy initiator.
//   state_e     : job sequencing states
//   WORD_BYTES  : address stride per transferred word
//   WSTRB_READ  : strobe pattern that marks a read on the native bus
//   WSTRB_WORD  : strobe pattern for a full 32-bit write
package dma_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = 4;

  localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;
  localparam logic [STRB_W-1:0] WSTRB_WORD = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_GAP = 3'd2,
    WR_REQ = 3'd3,
    WR_GAP = 3'd4,
    FIN    = 3'd5
  } state_e;

endpackage

// File: rtl/dma_copy_if.sv
// dma_copy_if: native memory bus (select/wstrb/addr/data/ready handshake).
//   master modport : the requesting side (dma_copy)
//   slave  modport : a ROM/SRAM style responder
//   mem_select : request, held until mem_ready
//   mem_addr   : byte address
//   mem_wstrb  : 0000 read, 1111 word write
//   mem_wdata  : write data
//   mem_rdata  : read data, valid with mem_ready && mem_select
//   mem_ready  : responder completion
interface dma_copy_if #(
  parameter int unsigned ADDR_W = 32
);
  import dma_copy_pkg::*;

  logic                mem_select;
  logic [ADDR_W-1:0]   mem_addr;
  logic [STRB_W-1:0]   mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport master (
    output mem_select,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_select,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/dma_copy.sv
// dma_copy: copies len 32-bit words from src_addr to dst_addr over the native
// memory bus, one read then one write per word, with one idle bus cycle after
// every completed transaction.
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle job request, only honoured in IDLE
//   src_addr/dst_addr : byte addresses, low two bits forced to zero
//   len             : word count (0 finishes immediately with no bus traffic)
//   fill_mode/fill_data : constant-fill job (only with DMA_COPY_FILL_EN)
//   busy, done      : job in progress / one-cycle completion pulse
//   words_done      : words written in the current (or last) job
//   bus             : dma_copy_if.master
// Build option: define DMA_COPY_FILL_EN to enable fill jobs, which skip the
// read phase and write fill_data to every destination word.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  dma_copy_if.master        bus
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_e             state;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  data_q;
`ifdef DMA_COPY_FILL_EN
  logic               fill_q;
`endif

  // Word-aligned views of the start addresses.
  logic [ADDR_W-1:0]  src_al;
  logic [ADDR_W-1:0]  dst_al;
  assign src_al = {src_addr[ADDR_W-1:2], 2'b00};
  assign dst_al = {dst_addr[ADDR_W-1:2], 2'b00};

  // A completion counts only while our own request is up; stale ready in a gap is ignored.
  logic xfer_ok;
  assign xfer_ok = bus.mem_select & bus.mem_ready;

`ifdef DMA_COPY_FILL_EN
  logic unused_in;
  assign unused_in = ^{src_addr[1:0], dst_addr[1:0]};
`else
  logic unused_in;
  assign unused_in = ^{src_addr[1:0], dst_addr[1:0], fill_mode, fill_data};
`endif

  // Job sequencer; all bus and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      words_done     <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      data_q         <= '0;
`ifdef DMA_COPY_FILL_EN
      fill_q         <= 1'b0;
`endif
      bus.mem_select <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wstrb  <= WSTRB_READ;
      bus.mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            words_done <= '0;
            if (len != '0) begin
              src_q <= src_al;
              dst_q <= dst_al;
              len_q <= len;
`ifdef DMA_COPY_FILL_EN
              fill_q <= fill_mode;
              if (fill_mode) begin
                // Fill jobs go straight to the write phase.
                data_q         <= fill_data;
                bus.mem_select <= 1'b1;
                bus.mem_addr   <= dst_al;
                bus.mem_wstrb  <= WSTRB_WORD;
                bus.mem_wdata  <= fill_data;
                state          <= WR_REQ;
              end else begin
                bus.mem_select <= 1'b1;
                bus.mem_addr   <= src_al;
                bus.mem_wstrb  <= WSTRB_READ;
                state          <= RD_REQ;
              end
`else
              bus.mem_select <= 1'b1;
              bus.mem_addr   <= src_al;
              bus.mem_wstrb  <= WSTRB_READ;
              state          <= RD_REQ;
`endif
            end else begin
              state <= FIN;
            end
          end
        end

        RD_REQ: begin
          if (xfer_ok) begin
            data_q         <= bus.mem_rdata;
            bus.mem_select <= 1'b0;
            state          <= RD_GAP;
          end
        end

        // Responders register ready from select, so ready lingers here one cycle.
        RD_GAP: begin
          bus.mem_select <= 1'b1;
          bus.mem_addr   <= dst_q;
          bus.mem_wstrb  <= WSTRB_WORD;
          bus.mem_wdata  <= data_q;
          state          <= WR_REQ;
        end

        WR_REQ: begin
          if (xfer_ok) begin
            bus.mem_select <= 1'b0;
            words_done     <= words_done + LEN_W'(1);
            src_q          <= src_q + STRIDE;
            dst_q          <= dst_q + STRIDE;
            state          <= WR_GAP;
          end
        end

        WR_GAP: begin
          if (words_done == len_q) begin
            state <= FIN;
          end
`ifdef DMA_COPY_FILL_EN
          else if (fill_q) begin
            bus.mem_select <= 1'b1;
            bus.mem_addr   <= dst_q;
            bus.mem_wstrb  <= WSTRB_WORD;
            bus.mem_wdata  <= data_q;
            state          <= WR_REQ;
          end
`endif
          else begin
            bus.mem_select <= 1'b1;
            bus.mem_addr   <= src_q;
            bus.mem_wstrb  <= WSTRB_READ;
            state          <= RD_REQ;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          bus.mem_select <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: scoreboard bench for dma_copy against a memory responder with
// programmable wait states and an optional stale ready after each completion.
module tb_dma_copy;
  import dma_copy_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic              fill_mode;
  logic [31:0]       fill_data;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;

  dma_copy_if #(.ADDR_W(ADDR_W)) bus ();

  dma_copy #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_mode  (fill_mode),
    .fill_data  (fill_data),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Responder: ready after wait_states cycles of select, optionally held one extra cycle.
  int   wait_states = 0;
  logic stale_en    = 1'b0;
  int   wait_cnt    = 0;
  logic stale_q     = 1'b0;

  assign bus.mem_ready = (bus.mem_select && (wait_cnt >= wait_states)) || stale_q;
  assign bus.mem_rdata = rd_pat(bus.mem_addr);

  always @(posedge clk) begin
    stale_q <= stale_en && bus.mem_select && bus.mem_ready;
    if (bus.mem_select && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  // Scoreboard and bus monitor.
  txn_t        exp_q[$];
  logic [31:0] wrote [logic [31:0]];
  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  int sel_cycles = 0;
  int gap_err = 0;
  int stab_err = 0;
  int done_pulses = 0;
  logic prev_cpl = 1'b0;
  logic prev_wait = 1'b0;
  txn_t prev_t;

  always @(negedge clk) begin
    txn_t cur;
    txn_t e;
    cur = '{bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
    if (reset) begin
      prev_cpl  = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (done) done_pulses++;
      if (bus.mem_select) sel_cycles++;
      if (prev_cpl && bus.mem_select) gap_err++;
      if (prev_wait && bus.mem_select && (cur !== prev_t)) stab_err++;
      if (bus.mem_select && bus.mem_ready) begin
        n_txn++;
        if (cur.wstrb == WSTRB_WORD) wrote[cur.addr] = cur.data;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL txn_unexpected: got addr=%h wstrb=%h wdata=%h, none expected",
                   cur.addr, cur.wstrb, cur.data);
        end else begin
          e = exp_q.pop_front();
          if (cur.addr !== e.addr || cur.wstrb !== e.wstrb ||
              (e.wstrb == WSTRB_WORD && cur.data !== e.data)) begin
            n_err++;
            $display("FAIL txn: got addr=%h wstrb=%h wdata=%h, want addr=%h wstrb=%h wdata=%h",
                     cur.addr, cur.wstrb, cur.data, e.addr, e.wstrb, e.data);
          end
        end
      end
      prev_cpl  = bus.mem_select && bus.mem_ready;
      prev_wait = bus.mem_select && !bus.mem_ready;
      prev_t    = cur;
    end
  end

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa;
    logic [31:0] da;
    txn_t t;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      t = '{sa, WSTRB_READ, 32'h0};
      exp_q.push_back(t);
      t = '{da, WSTRB_WORD, rd_pat(sa)};
      exp_q.push_back(t);
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  // Pulses start and returns the cycle (1 = first cycle after the start edge) in which done is seen.
  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input logic fm, input logic [31:0] fd, output int cyc);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; fill_mode = fm; fill_data = fd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill_mode = 1'b0; fill_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (words_done !== '0)   begin n_err++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
    n_cmp++; if (bus.mem_select !== 1'b0) begin n_err++; $display("FAIL reset_select: got %b want 0", bus.mem_select); end
    n_cmp++; if (bus.mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_wstrb !== 4'b0000) begin n_err++; $display("FAIL reset_wstrb: got %b want 0000", bus.mem_wstrb); end
    n_cmp++; if (bus.mem_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_copy_basic();
    int cyc;
    wait_states = 0; stale_en = 1'b0; wrote.delete();
    push_copy(32'h100, 32'h200, 3);
    start_job(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, cyc);
    n_cmp++; if (cyc !== 14) begin n_err++; $display("FAIL basic_latency: got %0d want 14", cyc); end
    n_cmp++; if (words_done !== 16'd3) begin n_err++; $display("FAIL basic_words_done: got %0d want 3", words_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL basic_missing_txns: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (!wrote.exists(32'h208) || wrote[32'h208] !== rd_pat(32'h108)) begin
      n_err++; $display("FAIL basic_last_word: got exists=%0d want data %h", wrote.exists(32'h208), rd_pat(32'h108));
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
  endtask

  task automatic test_zero_len();
    int cyc;
    sel_cycles = 0;
    start_job(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL zero_latency: got %0d want 2", cyc); end
    n_cmp++; if (sel_cycles !== 0) begin n_err++; $display("FAIL zero_select: got %0d cycles want 0", sel_cycles); end
    n_cmp++; if (words_done !== 16'd0) begin n_err++; $display("FAIL zero_words_done: got %0d want 0", words_done); end
  endtask

  task automatic test_wait_states();
    int cyc;
    wait_states = 3; stale_en = 1'b1; gap_err = 0; stab_err = 0;
    push_copy(32'h300, 32'h380, 2);
    start_job(32'h300, 32'h380, 16'd2, 1'b0, 32'h0, cyc);
    n_cmp++; if (cyc !== 22) begin n_err++; $display("FAIL wait_latency: got %0d want 22", cyc); end
    n_cmp++; if (gap_err !== 0) begin n_err++; $display("FAIL wait_gap: got %0d violations want 0", gap_err); end
    n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL wait_stable: got %0d changes want 0", stab_err); end
    n_cmp++; if (words_done !== 16'd2) begin n_err++; $display("FAIL wait_words_done: got %0d want 2", words_done); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL wait_missing_txns: got %0d left want 0", exp_q.size()); end
    wait_states = 0; stale_en = 1'b0;
  endtask

  task automatic test_wrap_align();
    int cyc;
    push_copy(32'hFFFF_FFFC, 32'h600, 2);
    start_job(32'hFFFF_FFFC, 32'h600, 16'd2, 1'b0, 32'h0, cyc);
    n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL wrap_latency: got %0d want 10", cyc); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL wrap_missing_txns: got %0d left want 0", exp_q.size()); end
    push_copy(32'h103, 32'h702, 1);
    start_job(32'h103, 32'h702, 16'd1, 1'b0, 32'h0, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL align_latency: got %0d want 6", cyc); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL align_missing_txns: got %0d left want 0", exp_q.size()); end
  endtask

`ifdef DMA_COPY_FILL_EN
  task automatic test_fill();
    int cyc;
    txn_t t;
    sel_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      t = '{32'h40 + 32'(4 * i), WSTRB_WORD, 32'hDEAD_BEEF};
      exp_q.push_back(t);
    end
    start_job(32'h800, 32'h40, 16'd4, 1'b1, 32'hDEAD_BEEF, cyc);
    n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL fill_latency: got %0d want 10", cyc); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL fill_missing_txns: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (words_done !== 16'd4) begin n_err++; $display("FAIL fill_words_done: got %0d want 4", words_done); end
  endtask
`else
  task automatic test_fill();
    int cyc;
    push_copy(32'h880, 32'h40, 1);
    start_job(32'h880, 32'h40, 16'd1, 1'b1, 32'hDEAD_BEEF, cyc);
    n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL fill_ignored_latency: got %0d want 6", cyc); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL fill_ignored_txns: got %0d left want 0", exp_q.size()); end
  endtask
`endif

  task automatic test_restart_and_reset();
    int   cyc;
    int   base;
    txn_t t;
    wait_states = 3; stale_en = 1'b1; wrote.delete();
    push_copy(32'h400, 32'h500, 1);
    t = '{32'h404, WSTRB_READ, 32'h0};
    exp_q.push_back(t);
    base = n_txn;
    @(negedge clk);
    src_addr = 32'h400; dst_addr = 32'h500; len = 16'd3; fill_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", busy); end
    repeat (4) @(negedge clk);
    src_addr = 32'h900; dst_addr = 32'hA00; len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(n_txn == base + 3 && bus.mem_select === 1'b1 && bus.mem_wstrb === WSTRB_WORD) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc >= 200) begin n_err++; $display("FAIL restart_reach_wr2: got timeout want WR_REQ of word 2"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_select !== 1'b0) begin n_err++; $display("FAIL reset_mid_select: got %b want 0", bus.mem_select); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    reset = 1'b0;
    done_pulses = 0;
    repeat (10) @(negedge clk);
    n_cmp++; if (done_pulses !== 0) begin n_err++; $display("FAIL reset_mid_done: got %0d pulses want 0", done_pulses); end
    n_cmp++; if (wrote.exists(32'h504)) begin n_err++; $display("FAIL reset_mid_word2: got written %h want unwritten", wrote[32'h504]); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL restart_txns: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (bus.mem_select !== 1'b0) begin n_err++; $display("FAIL reset_mid_idle: got %b want 0", bus.mem_select); end
    wait_states = 0; stale_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_copy_basic();
    test_zero_len();
    test_wait_states();
    test_wrap_align();
    test_fill();
    test_restart_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Bus initiator for the picoRV native memory interface: the requesting side of the select/wstrb/addr/data/ready handshake that ROM/SRAM responders serve.
- Copies LEN 32-bit words from a source byte address to a destination byte address, one read then one write per word.
- Sits beside the CPU on the SoC bus, behind the arbiter; started by a one-cycle start pulse from a control register block.

Parameters:
- ADDR_W, 32, bus address width (byte addresses).
- LEN_W, 16, width of the word-count input and progress counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- fill_mode  in  1  fill request (used only with DMA_COPY_FILL_EN)
- fill_data  in  32  fill pattern (used only with DMA_COPY_FILL_EN)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- words_done  out  LEN_W  words written so far in the current job
- mem_select  out  1  transaction request, held until ready
- mem_addr  out  ADDR_W  transaction byte address
- mem_wstrb  out  4  4'b0000 = read, 4'b1111 = write
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid when mem_ready and mem_select are both high
- mem_ready  in  1  responder completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: busy=0, done=0, words_done=0, mem_select=0, mem_addr=0, mem_wstrb=0, mem_wdata=0. State=IDLE.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN.
- IDLE:
  - On start with len!=0: latch src, dst and len; clear words_done; busy=1; go to RD_REQ. mem_select rises at that same edge.
  - On start with len==0: go to FIN with no bus activity.
- RD_REQ:
  - mem_select=1, mem_wstrb=0, mem_addr=src.
  - Completion only when mem_ready=1 while mem_select=1. At that edge, capture mem_rdata into the data register, drop mem_select, and go to RD_GAP.
- RD_GAP:
  - Exactly one cycle with mem_select=0. Required because responders register ready<=select, so ready stays high one cycle after select falls.
  - Any mem_ready seen while mem_select=0 is ignored.
- WR_REQ:
  - mem_select=1, mem_wstrb=4'b1111, mem_addr=dst, mem_wdata=captured word.
  - On qualified ready: drop select; words_done+1; src+=4 and dst+=4 (modulo 2^ADDR_W, wrap silently); go to WR_GAP.
- WR_GAP:
  - One idle cycle.
  - If words_done==len, go to FIN; else go to RD_REQ.
- FIN: done=1 for one cycle, busy=0, return to IDLE. words_done holds its final value until the next accepted start.
- Latency against a one-cycle responder: 4 cycles per word (2 read + 2 write, with gaps inside). Total = 4*len + 2 cycles from start to done.
- Wait states: mem_select and mem_addr/wstrb/wdata stay stable for any number of cycles until ready.
- start while busy: ignored, no effect on the current job.
- Reset mid-transaction: mem_select drops at the reset edge and the job is abandoned, with no done pulse.
- Max len = 2^LEN_W-1. words_done never wraps.

Optional Feature:
- Macro DMA_COPY_FILL_EN.
- Defined: if fill_mode=1 at the accepted start, fill_data is latched. RD_REQ/RD_GAP are skipped, every write uses fill_data, and src is not used. Cost is 2 cycles per word; total = 2*len + 2.
- Undefined: fill_mode and fill_data are ignored; the block is copy-only.

Decomposition:
- Package dma_copy_pkg holds:
  - state enum (IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN)
  - WORD_BYTES=4
  - WSTRB_READ=4'b0000
  - WSTRB_WORD=4'b1111
- No sub-module: a single FSM with address and count registers. The bench reuses the existing ROM/SRAM responders as bus models.

Test Plan:
- Reset → all outputs 0. Then start, src=0x100, dst=0x200, len=3, one-cycle responder → reads 0x100/0x104/0x108 and writes 0x200/0x204/0x208 with matching data; done at cycle 14 after start; words_done=3.
- len=0 start → done exactly 2 cycles later, mem_select never asserts, words_done=0.
- Responder with 3 wait states plus a stale ready held one cycle after select falls → no false completion; addr/wstrb/wdata stable while waiting; a single select gap between transactions.
- start pulsed again mid-job; reset asserted during WR_REQ of word 2 → second start ignored; after reset, mem_select=0 and busy=0, no done pulse, dst word 2 unwritten.
- src=0xFFFFFFFC, len=2 → second read at address 0x00000000 (wrap). Unaligned src=0x103 → read issued at 0x100.
- DMA_COPY_FILL_EN defined, fill_mode=1, fill_data=0xDEADBEEF, dst=0x40, len=4 → four writes of 0xDEADBEEF to 0x40..0x4C, no reads, done 10 cycles after start.
